// File: rtl/boot_loader_ctrl.sv
// Bootloader sequencer: parses framed bytes, writes 16-bit words to IM/DM
// through the debug port, then releases the CPU on a GO command.
module boot_loader_ctrl #(
    parameter int IM_AW  = 16,
    parameter int DM_AW  = 13,
    parameter int TO_CYC = 1000000,
    parameter int TO_W   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        debug,
    output logic        cpu_rst_n,
    output logic [15:0] wr_data,
    output logic [15:0] in_addr,
    output logic        im_wr,
    output logic        dm_wr,
    output logic        frame_ok,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA_H, S_DATA_L, S_WRITE, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam logic [16:0] IM_LIM = 17'(1) << IM_AW;
    localparam logic [16:0] DM_LIM = 17'(1) << DM_AW;

    state_t          r_state;
    logic            r_tgt_dm;
    logic            r_range_ok;
    logic [7:0]      r_hi;
    logic [7:0]      r_csum;
    logic [15:0]     r_addr;
    logic [15:0]     r_cnt;
    logic [TO_W-1:0] r_to;
    logic [15:0]     r_wr_data;
    logic [15:0]     r_in_addr;
    logic            r_im_wr;
    logic            r_dm_wr;
    logic            r_frame_ok;
    logic            r_err;
    logic            r_debug;
    logic            r_cpu_rst_n;

    logic w_acc;
    logic w_mid;
    logic w_in_range;
    logic w_timeout;
    logic [15:0] w_cnt_in;

    assign rx_ready = !rst && (r_state != S_WRITE)
                      && (r_state != S_RUN);
    assign w_acc = rx_valid && rx_ready;

    // Timeout only runs while waiting for a byte inside a frame
    assign w_mid = (r_state != S_IDLE) && (r_state != S_RUN)
                   && (r_state != S_ERR) && (r_state != S_WRITE);
    assign w_timeout = w_mid && !w_acc
                       && (r_to == TO_W'(TO_CYC - 1));

    assign w_in_range = r_tgt_dm ? ({1'b0, r_addr} < DM_LIM)
                                 : ({1'b0, r_addr} < IM_LIM);
    assign w_cnt_in = {r_hi, rx_data};

    assign wr_data   = r_wr_data;
    assign in_addr   = r_in_addr;
    assign im_wr     = r_im_wr;
    assign dm_wr     = r_dm_wr;
    assign frame_ok  = r_frame_ok;
    assign err       = r_err;
    assign debug     = r_debug;
    assign cpu_rst_n = r_cpu_rst_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tgt_dm    <= 1'b0;
            r_range_ok  <= 1'b0;
            r_hi        <= '0;
            r_csum      <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_to        <= '0;
            r_wr_data   <= '0;
            r_in_addr   <= '0;
            r_im_wr     <= 1'b0;
            r_dm_wr     <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_err       <= 1'b0;
            r_debug     <= 1'b1;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_im_wr    <= 1'b0;
            r_dm_wr    <= 1'b0;
            r_frame_ok <= 1'b0;

            if (w_acc || !w_mid)
                r_to <= '0;
            else
                r_to <= r_to + 1'b1;

            if (w_timeout) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: if (w_acc) begin
                        r_csum <= rx_data;
                        unique case (rx_data)
                            8'h49: begin
                                r_tgt_dm <= 1'b0;
                                r_state  <= S_ADDR_H;
                            end
                            8'h44: begin
                                r_tgt_dm <= 1'b1;
                                r_state  <= S_ADDR_H;
                            end
                            8'h47: begin
                                r_state     <= S_RUN;
                                r_debug     <= 1'b0;
                                r_cpu_rst_n <= 1'b1;
                            end
                            default: begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                    S_ADDR_H: if (w_acc) begin
                        r_hi    <= rx_data;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= S_ADDR_L;
                    end
                    S_ADDR_L: if (w_acc) begin
                        r_addr  <= w_cnt_in;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= S_CNT_H;
                    end
                    S_CNT_H: if (w_acc) begin
                        r_hi    <= rx_data;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= S_CNT_L;
                    end
                    S_CNT_L: if (w_acc) begin
                        r_cnt   <= w_cnt_in;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= (w_cnt_in == '0) ? S_CSUM
                                                    : S_DATA_H;
                    end
                    S_DATA_H: if (w_acc) begin
                        r_hi    <= rx_data;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= S_DATA_L;
                    end
                    // Strobe is registered here so it lands in WRITE
                    S_DATA_L: if (w_acc) begin
                        r_csum     <= r_csum ^ rx_data;
                        r_wr_data  <= w_cnt_in;
                        r_in_addr  <= r_addr;
                        r_im_wr    <= w_in_range && !r_tgt_dm;
                        r_dm_wr    <= w_in_range && r_tgt_dm;
                        r_range_ok <= w_in_range;
                        r_state    <= S_WRITE;
                    end
                    S_WRITE: begin
                        r_addr <= r_addr + 16'd1;
                        r_cnt  <= r_cnt - 16'd1;
                        if (!r_range_ok) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (r_cnt == 16'd1) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA_H;
                        end
                    end
                    S_CSUM: if (w_acc) begin
                        if (rx_data == r_csum) begin
                            r_frame_ok <= 1'b1;
                            r_csum     <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    S_RUN: r_state <= S_RUN;
                    S_ERR: r_state <= S_ERR;
                    default: begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
